cpu_multicycle: RTL
===================

Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle core. It implements an RV32I integer subset: ADD, SUB, AND, OR, ADDI, LW, SW, BEQ, BNE.
- Instructions are fetched through a request/acknowledge instruction port. Loads and stores use a separate request/acknowledge data port, so memories may insert wait states.
- It sits between instruction memory and data memory, with a control FSM replacing the old purely combinational sequencing.
- It adds sticky illegal-instruction and misalignment trapping, configurable register count and a configurable reset vector.

Parameters:
- NREG, 32, number of architectural registers; legal values 16 (RV32E) or 32. Register indices >= NREG are illegal.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width. This is a fixed localparam and is not overridable.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  fetch done; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data request; held high until acknowledged.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req is high.
- dmem_addr  out  32  byte address, word-aligned.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  data done; dmem_rdata is valid in the same cycle for loads.
- dmem_rdata  in  32  load data.
- retire  out  1  one-cycle pulse per completed instruction.
- pc_out  out  32  current architectural PC.
- trap  out  1  sticky; set on an illegal or misaligned instruction.

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to FETCH; pc = RESET_PC; all registers = 0.
  - imem_req, dmem_req, dmem_we, retire, trap = 0.
  - This overrides any state, including a pending memory handshake. An outstanding request is abandoned; memories must tolerate a dropped request.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_ack=1: latch the instruction into ir, go to DECODE.
  - An ack arriving in the first request cycle is accepted (zero-wait).
- DECODE:
  - Read rs1/rs2 and generate the immediate (I/S/B types, sign-extended per RV32I).
  - Illegal cases go to TRAP:
    - unknown opcode, funct3 or funct7;
    - any of rs1, rs2 or rd >= NREG.
  - Otherwise go to EXEC.
- EXEC:
  - ALU result: ADD/ADDI = sum; SUB = difference; AND; OR. Arithmetic is modulo 2^32.
  - Branch compare: BEQ taken if rs1==rs2; BNE taken if rs1!=rs2.
  - Branch target = pc + imm_b; next_pc = taken ? target : pc+4. Wrap-around is modulo 2^32.
  - Taken branch with target[1:0] != 0 goes to TRAP.
  - LW/SW address = rs1 + imm. If addr[1:0] != 0, go to TRAP without issuing dmem_req. Otherwise go to MEM.
  - All other instructions go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for SW; dmem_addr/dmem_wdata driven from registered values.
  - On an edge with ack=1: LW latches dmem_rdata; go to WB.
- WB:
  - Write rd for R-type, ADDI and LW. Writes to x0 are discarded; x0 always reads 0.
  - pc <= next_pc; retire=1 for this cycle; go to FETCH.
- TRAP:
  - trap=1 and pc frozen at the faulting instruction.
  - No requests are issued and no register write occurs.
  - Exit only via reset.
- Latency with zero-wait memory:
  - R-type, ADDI, branches: 4 cycles (F, D, E, W).
  - LW/SW: 5 cycles.
  - Each wait cycle of imem_ack or dmem_ack adds 1 cycle.
- Simultaneous events: reset wins over ack. At most one of imem_req and dmem_req is ever high.

Decomposition:
- Package cpu_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP};
  - alu_op enum {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
  - opcode constants (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011);
  - funct3/funct7 constants.
- Sub-module regfile, parametrised by NREG:
  - two asynchronous read ports, one synchronous write port;
  - x0 hardwired to 0; synchronous active-low clear.

Test Plan:
1. Reset: hold reset=0 for 3 cycles in mid-FETCH -> imem_req=0, pc_out=RESET_PC, trap=0. Release -> next cycle imem_req=1, imem_addr=0.
2. Zero-wait arithmetic: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=0xFFFF_FFF8. Retire pulses exactly 4 times, 4 cycles apart; ADDI x0,x0,7 leaves x0=0.
3. Memory with waits: SW x1,8(x0) with dmem_ack delayed 2 cycles -> dmem_req high 3 cycles, dmem_we=1, addr=8, wdata=5. Then LW x5,8(x0) -> x5=5, instruction takes 7 cycles.
4. Branches at pc=0x10 with x1=x2: BEQ x1,x2,-8 -> pc=0x08. BNE x1,x2,+16 -> pc=0x14. Branch -0x10 from pc=0x08 -> pc wraps to 0xFFFF_FFF8.
5. Traps:
   - instruction 0x0000_0000 -> trap=1, pc frozen, imem_req stays 0;
   - LW x1,2(x0) -> trap=1, dmem_req never asserted;
   - NREG=16 with ADD x17,x1,x2 -> trap=1.
6. Reset mid-MEM: reset=0 while dmem_req=1 and no ack -> next cycle dmem_req=0, pc=RESET_PC, x1=0. The first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I core.
// Holds the FSM state enum, ALU operation enum and the opcode /
// funct3 / funct7 constants for the supported instruction subset.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;  // ADD/SUB/ADDI
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_W   = 3'b010;  // LW/SW
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one
// synchronous write port, x0 hardwired to zero, synchronous active-low
// clear. Indices >= NREG read as zero and are never written.
//   clk, reset       : clock, synchronous active-low clear
//   ra1/ra2, rd1/rd2 : read addresses / data
//   we, wa, wd       : write enable / address / data
module regfile
  import cpu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  function automatic logic live(input logic [4:0] r);
    return (r != 5'd0) && ({27'd0, r} < 32'(NREG));
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && live(wa)) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  assign rd1 = live(ra1) ? regs[ra1[AW-1:0]] : '0;
  assign rd2 = live(ra2) ? regs[ra2[AW-1:0]] : '0;

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I subset core (ADD SUB AND OR ADDI LW SW BEQ BNE).
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a sticky TRAP state for
// illegal encodings, out-of-range registers and misaligned accesses or
// branch targets.
//   clk, reset                   : clock, synchronous active-low reset
//   imem_req/addr/ack/rdata      : instruction fetch handshake
//   dmem_req/we/addr/wdata/ack/rdata : load/store handshake
//   retire                       : one pulse per completed instruction
//   pc_out                       : architectural PC
//   trap                         : high once a fault is hit, until reset
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic [XLEN-1:0] pc_out,
  output logic            trap
);

  state_t state, state_nx;
  logic run;  // low for the first cycle after reset so imem_req stays low in reset
  logic [XLEN-1:0] pc, ir, a, b, imm, res, npc;

  // ---- decode (ir is held from FETCH until the next fetch) ----
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic            legal, use_rs1, use_rs2, use_rd;
  alu_op_t         alu_op;
  logic [XLEN-1:0] imm_dec;

  function automatic logic bad_reg(input logic [4:0] r);
    return {27'd0, r} >= 32'(NREG);
  endfunction

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    alu_op  = ALU_ADD;
    imm_dec = '0;
    case (opc)
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD}: begin legal = 1'b1; alu_op = ALU_ADD; end
          {F7_SUB,  F3_ADD}: begin legal = 1'b1; alu_op = ALU_SUB; end
          {F7_BASE, F3_AND}: begin legal = 1'b1; alu_op = ALU_AND; end
          {F7_BASE, F3_OR }: begin legal = 1'b1; alu_op = ALU_OR;  end
          default: ;
        endcase
      end
      OP_I, OP_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        legal   = (opc == OP_I) ? (f3 == F3_ADD) : (f3 == F3_W);
        imm_dec = {{20{ir[31]}}, ir[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        legal   = (f3 == F3_W);
        imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        legal   = (f3 == F3_BEQ) || (f3 == F3_BNE);
        imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      default: ;
    endcase
    // Only fields the instruction actually uses as registers are range checked;
    // the others are immediate bits.
    if ((use_rs1 && bad_reg(rs1)) || (use_rs2 && bad_reg(rs2)) ||
        (use_rd && bad_reg(rd)))
      legal = 1'b0;
  end

  logic is_mem, is_store, writes_rd;
  assign is_store  = (opc == OP_STORE);
  assign is_mem    = (opc == OP_LOAD) || is_store;
  assign writes_rd = (opc == OP_R) || (opc == OP_I) || (opc == OP_LOAD);

  // ---- execute ----
  logic [XLEN-1:0] opb, alu_y, br_tgt;
  logic            taken;
  assign opb    = (opc == OP_R) ? b : imm;
  assign br_tgt = pc + imm;
  assign taken  = (opc == OP_BRANCH) && ((f3 == F3_BNE) ? (a != b) : (a == b));

  always_comb begin
    alu_y = a + opb;
    case (alu_op)
      ALU_SUB: alu_y = a - opb;
      ALU_AND: alu_y = a & opb;
      ALU_OR:  alu_y = a | opb;
      default: ;
    endcase
  end

  // ---- register file ----
  logic [XLEN-1:0] rd1, rd2;
  regfile #(.NREG(NREG)) u_rf (
    .clk(clk), .reset(reset),
    .ra1(rs1), .ra2(rs2), .rd1(rd1), .rd2(rd2),
    .we(state == WB && writes_rd), .wa(rd), .wd(res)
  );

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (run && imem_ack) state_nx = DECODE;
      DECODE: state_nx = legal ? EXEC : TRAP;
      EXEC: begin
        if (taken)       state_nx = (br_tgt[1:0] != 2'b00) ? TRAP : WB;
        else if (is_mem) state_nx = (alu_y[1:0] != 2'b00) ? TRAP : MEM;
        else             state_nx = WB;
      end
      MEM:    if (dmem_ack) state_nx = WB;
      WB:     state_nx = FETCH;
      TRAP:   state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      run <= 1'b0;
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      imm <= '0;
      res <= '0;
      npc <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH:  if (run && imem_ack) ir <= imem_rdata;
        DECODE: begin a <= rd1; b <= rd2; imm <= imm_dec; end
        EXEC: begin
          res <= alu_y;  // ALU result, or byte address for LW/SW
          npc <= taken ? br_tgt : pc + 32'd4;
        end
        MEM:    if (dmem_ack && !is_store) res <= dmem_rdata;
        WB:     pc <= npc;
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == FETCH) && run;
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && is_store;
  assign dmem_addr  = res;
  assign dmem_wdata = b;
  assign retire     = (state == WB);
  assign pc_out     = pc;
  assign trap       = (state == TRAP);

endmodule
